// File: rtl/bus_fetch_ctrl.sv
// rtl/bus_fetch_ctrl.sv - instruction fetch and memory bus sequencer with per-region wait states
// Optional bus_err output is enabled by defining BUS_FETCH_CTRL_BUS_ERR_EN.
module bus_fetch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int INSTR_W = 16,
  parameter int OFF_W = 8,
  parameter int RESET_PC = 0,
  parameter logic [ADDR_W-1:0] RAM_BASE = 'h8000,
  parameter logic [ADDR_W-1:0] FLASH_BASE = 'hC000,
  parameter int WAIT_PROM = 2,
  parameter int WAIT_RAM = 1,
  parameter int WAIT_FLASH = 4,
  localparam int BEATS = INSTR_W / DATA_W,
  localparam int LOG_B = $clog2(BEATS),
  localparam int PC_W = ADDR_W - LOG_B
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              prom_oe_n,
  output logic              ram_oe_n,
  output logic              flash_oe_n,
  output logic              ram_we_n,
  output logic [PC_W-1:0]   pc,
  output logic [INSTR_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_en,
  input  logic [OFF_W-1:0]  jmp_off,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] ld_data,
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
  output logic              ls_done,
  output logic              bus_err
`else
  output logic              ls_done
`endif
);

  localparam int BEAT_W = (LOG_B > 0) ? LOG_B : 1;

  localparam logic [1:0] S_TURN   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_DATA   = 2'd3;

  logic [1:0]        state;
  logic [BEAT_W-1:0] beat;
  logic [7:0]        wcnt;
  logic              ld_pend;
  logic              st_pend;
  logic [ADDR_W-1:0] ls_addr_q;
  logic [DATA_W-1:0] st_data_q;
  logic [ADDR_W-1:0] fetch_addr;
  logic [PC_W-1:0]   step;
  logic              is_prom;
  logic              is_ram;
  logic              is_flash;
  logic              rd_active;
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
  logic              drop_q;
`endif

  function automatic logic [7:0] region_wait(input logic [ADDR_W-1:0] a);
    if (a < RAM_BASE) return 8'(WAIT_PROM);
    else if (a < FLASH_BASE) return 8'(WAIT_RAM);
    else return 8'(WAIT_FLASH);
  endfunction

  assign fetch_addr = (ADDR_W'(pc) << LOG_B) | ADDR_W'(beat);
  assign step = jmp_en ? {{(PC_W-OFF_W){jmp_off[OFF_W-1]}}, jmp_off} : PC_W'(1);

  // Strobes decode from registered state and address, so they are low exactly in access cycles.
  assign is_prom   = (mem_addr < RAM_BASE);
  assign is_ram    = !is_prom && (mem_addr < FLASH_BASE);
  assign is_flash  = !is_prom && !is_ram;
  assign rd_active = (state == S_ACCESS) || ((state == S_DATA) && ld_pend);

  assign prom_oe_n  = !(rd_active && is_prom);
  assign ram_oe_n   = !(rd_active && is_ram);
  assign flash_oe_n = !(rd_active && is_flash);
  assign ram_we_n   = !((state == S_DATA) && st_pend && is_ram);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_TURN;
      beat        <= '0;
      wcnt        <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pc          <= PC_W'(RESET_PC);
      instr       <= '0;
      instr_valid <= 1'b0;
      ld_data     <= '0;
      ls_done     <= 1'b0;
      ld_pend     <= 1'b0;
      st_pend     <= 1'b0;
      ls_addr_q   <= '0;
      st_data_q   <= '0;
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
      drop_q      <= 1'b0;
      bus_err     <= 1'b0;
`endif
    end else begin
      ls_done <= 1'b0;
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
      bus_err <= 1'b0;
`endif
      case (state)
        S_TURN: begin
          if (ld_pend || st_pend) begin
            mem_addr <= ls_addr_q;
            if (st_pend) mem_wdata <= st_data_q;
            wcnt  <= region_wait(ls_addr_q);
            state <= S_DATA;
          end else begin
            mem_addr <= fetch_addr;
            wcnt     <= region_wait(fetch_addr);
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
          end else begin
            // Shifting in from the bottom leaves beat 0 in the MSBs (big-endian).
            instr <= (instr << DATA_W) | INSTR_W'(mem_rdata);
            if (beat == BEAT_W'(BEATS - 1)) begin
              beat        <= '0;
              instr_valid <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              beat  <= beat + BEAT_W'(1);
              state <= S_TURN;
            end
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            pc          <= pc + step;
            instr_valid <= 1'b0;
            ld_pend     <= ld_req;
            st_pend     <= st_req && !ld_req;
            ls_addr_q   <= ls_addr;
            st_data_q   <= st_data;
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
            drop_q      <= ld_req && st_req;
`endif
            state       <= S_TURN;
          end
        end
        default: begin
          if (wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
          end else begin
            if (ld_pend) ld_data <= mem_rdata;
            ls_done <= 1'b1;
`ifdef BUS_FETCH_CTRL_BUS_ERR_EN
            bus_err <= (st_pend && !is_ram) || drop_q;
            drop_q  <= 1'b0;
`endif
            ld_pend <= 1'b0;
            st_pend <= 1'b0;
            state   <= S_TURN;
          end
        end
      endcase
    end
  end

endmodule
